// File: rtl/fp_pkg.sv
// ----------------------------------------------------------------------------
// fp_pkg
// Shared types and constants for the FP32 add/subtract sequencer.
//   fsm_state_t : sequencer states
//   fp32_t      : FP32 field view {sign, exp, frac}
//   EXP_W/MAN_W : FP32 field widths, BIAS the exponent bias
//   QNAN/POS_INF/NEG_INF : canonical special encodings
// ----------------------------------------------------------------------------
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;

    typedef enum logic [2:0] {
        IDLE,
        SPECIAL,
        EXP,
        ALIGN,
        MANT,
        NORM,
        DONE
    } fsm_state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp32_t;

    // Zero, denormal, Inf and NaN all bypass the arithmetic path.
    function automatic logic is_special(input fp32_t x);
        return (x.exp == '0) || (x.exp == '1);
    endfunction

endpackage

// File: rtl/addsub_block.sv
// ----------------------------------------------------------------------------
// addsub_block
// 24-bit adder/subtractor shared by the FP sequencer.
//   a_in, b_in : operands
//   sel        : 0 = a_in + b_in, 1 = a_in - b_in (two's complement)
//   sum        : low 24 bits of the result
//   c_out      : carry out (on subtract: 1 means no borrow)
// ----------------------------------------------------------------------------
module addsub_block (
    input  logic [23:0] a_in,
    input  logic [23:0] b_in,
    input  logic        sel,
    output logic [23:0] sum,
    output logic        c_out
);

    logic [23:0] b_eff;

    assign b_eff        = sel ? ~b_in : b_in;
    assign {c_out, sum} = {1'b0, a_in} + {1'b0, b_eff} + {24'd0, sel};

endmodule

// File: rtl/lzc24.sv
// ----------------------------------------------------------------------------
// lzc24
// Combinational leading-zero counter for a 24-bit value.
//   value : input vector
//   count : number of leading zeros from bit 23 down; 24 when value is zero
// ----------------------------------------------------------------------------
module lzc24 (
    input  logic [23:0] value,
    output logic [4:0]  count
);

    logic found;

    always_comb begin
        count = 5'd24;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found && value[i]) begin
                count = 5'(23 - i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_addsub_seq.sv
// ----------------------------------------------------------------------------
// fp_addsub_seq
// Multi-cycle FP32 add/subtract. One operation in flight; a single
// addsub_block is time-shared for exponent compare, mantissa add/sub and
// exponent adjust. Denormals flush to zero, alignment truncates.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : operand handshake (ready only in IDLE)
//   op_a_in, op_b_in     : FP32 operands, sub_in selects A-B
//   out_valid/out_ready  : result handshake
//   result               : FP32 result
//   overflow/underflow   : saturated to Inf / flushed to zero
//   invalid              : NaN operand or Inf-Inf
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for operands
// SPECIAL | zero/denormal/Inf/NaN operand, result chosen directly
// EXP     | order operands by magnitude, exponent difference via block
// ALIGN   | shift smaller mantissa right by the difference
// MANT    | mantissa add or subtract via block
// NORM    | normalise, exponent adjust via block, range check
// DONE    | publish result, hold until out_ready
// ----------------------------------------------------------------------------
module fp_addsub_seq
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a_in,
    input  logic [31:0] op_b_in,
    input  logic        sub_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        invalid
);

    fsm_state_t state;

    fp32_t op_a, op_b;
    fp32_t a_q, b_q;               // b_q carries the effective sign of B

    logic                big_sign;
    logic                eff_sub;
    logic [EXP_W-1:0]    big_exp;
    logic [MAN_W:0]      big_man;
    logic [MAN_W:0]      sml_man;
    logic [23:0]         blk_q;     // registered block output
    logic                carry_q;

    logic [31:0]         res_stage;
    logic                ovf_stage, unf_stage, inv_stage;

    logic [23:0]         blk_a, blk_b, blk_sum;
    logic                blk_sel, blk_cout;

    logic [4:0]          lzc_cnt;

    assign op_a = op_a_in;
    assign op_b = op_b_in;

    addsub_block u_addsub (
        .a_in  (blk_a),
        .b_in  (blk_b),
        .sel   (blk_sel),
        .sum   (blk_sum),
        .c_out (blk_cout)
    );

    lzc24 u_lzc (
        .value (blk_q),
        .count (lzc_cnt)
    );

    // ---------------- special-operand result ----------------
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [31:0] spec_res;
    logic        spec_inv;

    always_comb begin
        a_nan  = (a_q.exp == '1) && (a_q.frac != '0);
        b_nan  = (b_q.exp == '1) && (b_q.frac != '0);
        a_inf  = (a_q.exp == '1) && (a_q.frac == '0);
        b_inf  = (b_q.exp == '1) && (b_q.frac == '0);
        a_zero = (a_q.exp == '0);
        b_zero = (b_q.exp == '0);
        spec_res = '0;
        spec_inv = 1'b0;
        if (a_nan || b_nan || (a_inf && b_inf && (a_q.sign != b_q.sign))) begin
            spec_res = QNAN;
            spec_inv = 1'b1;
        end else if (a_inf) begin
            spec_res = a_q;
        end else if (b_inf) begin
            spec_res = b_q;
        end else if (a_zero && b_zero) begin
            spec_res = (a_q.sign == b_q.sign) ? {a_q.sign, 31'd0} : 32'd0;
        end else if (a_zero) begin
            spec_res = b_q;
        end else begin
            spec_res = a_q;
        end
    end

    // ---------------- magnitude ordering ----------------
    logic             a_first;
    logic [EXP_W-1:0] l_exp_c, s_exp_c;
    logic [MAN_W:0]   l_man_c, s_man_c;
    logic             l_sign_c;

    always_comb begin
        a_first  = (a_q.exp > b_q.exp) ||
                   ((a_q.exp == b_q.exp) && (a_q.frac >= b_q.frac));
        l_exp_c  = a_first ? a_q.exp : b_q.exp;
        s_exp_c  = a_first ? b_q.exp : a_q.exp;
        l_man_c  = a_first ? {1'b1, a_q.frac} : {1'b1, b_q.frac};
        s_man_c  = a_first ? {1'b1, b_q.frac} : {1'b1, a_q.frac};
        l_sign_c = a_first ? a_q.sign : b_q.sign;
    end

    // ---------------- normalisation ----------------
    logic                norm_carry;
    logic [MAN_W-1:0]    frac_norm;
    logic signed [23:0]  exp_adj;

    always_comb begin
        norm_carry = !eff_sub && carry_q;
        // With a carry the 25-bit sum's top bit is the hidden bit.
        frac_norm  = norm_carry ? blk_q[23:1] : 23'(blk_q << lzc_cnt);
        exp_adj    = signed'(blk_sum);
    end

    // ---------------- shared block operand mux ----------------
    always_comb begin
        blk_a   = '0;
        blk_b   = '0;
        blk_sel = 1'b0;
        case (state)
            EXP: begin
                blk_a   = {16'd0, l_exp_c};
                blk_b   = {16'd0, s_exp_c};
                blk_sel = 1'b1;
            end
            MANT: begin
                blk_a   = big_man;
                blk_b   = sml_man;
                blk_sel = eff_sub;
            end
            NORM: begin
                blk_a   = {16'd0, big_exp};
                blk_b   = norm_carry ? 24'd1 : {19'd0, lzc_cnt};
                blk_sel = !norm_carry;
            end
            default: ;
        endcase
    end

    // ---------------- sequencer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            invalid   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            big_sign  <= 1'b0;
            eff_sub   <= 1'b0;
            big_exp   <= '0;
            big_man   <= '0;
            sml_man   <= '0;
            blk_q     <= '0;
            carry_q   <= 1'b0;
            res_stage <= '0;
            ovf_stage <= 1'b0;
            unf_stage <= 1'b0;
            inv_stage <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= op_a;
                        b_q      <= {op_b.sign ^ sub_in, op_b.exp, op_b.frac};
                        in_ready <= 1'b0;
                        state    <= (is_special(op_a) || is_special(op_b)) ? SPECIAL : EXP;
                    end
                end
                SPECIAL: begin
                    res_stage <= spec_res;
                    inv_stage <= spec_inv;
                    ovf_stage <= 1'b0;
                    unf_stage <= 1'b0;
                    state     <= DONE;
                end
                EXP: begin
                    blk_q    <= blk_sum;
                    big_exp  <= l_exp_c;
                    big_man  <= l_man_c;
                    sml_man  <= s_man_c;
                    big_sign <= l_sign_c;
                    eff_sub  <= a_q.sign ^ b_q.sign;
                    state    <= ALIGN;
                end
                ALIGN: begin
                    if (blk_q >= 24'd24) begin
                        sml_man <= '0;
                    end else begin
                        sml_man <= sml_man >> blk_q[4:0];
                    end
                    state <= MANT;
                end
                MANT: begin
                    blk_q   <= blk_sum;
                    carry_q <= blk_cout;
                    state   <= NORM;
                end
                NORM: begin
                    ovf_stage <= 1'b0;
                    unf_stage <= 1'b0;
                    inv_stage <= 1'b0;
                    if (!norm_carry && (blk_q == '0)) begin
                        res_stage <= '0;
                    end else if (exp_adj >= 24'sd255) begin
                        res_stage <= big_sign ? NEG_INF : POS_INF;
                        ovf_stage <= 1'b1;
                    end else if (exp_adj <= 24'sd0) begin
                        res_stage <= {big_sign, 31'd0};
                        unf_stage <= 1'b1;
                    end else begin
                        res_stage <= {big_sign, exp_adj[7:0], frac_norm};
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        result    <= res_stage;
                        overflow  <= ovf_stage;
                        underflow <= unf_stage;
                        invalid   <= inv_stage;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        invalid   <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// ----------------------------------------------------------------------------
// tb_fp_addsub_seq
// Directed-vector bench for fp_addsub_seq with hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_fp_addsub_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op_a_in = '0;
    logic [31:0] op_b_in = '0;
    logic        sub_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        overflow, underflow, invalid;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] exp_res;
        logic [2:0]  exp_flags;   // {overflow, underflow, invalid}
        int          exp_lat;
    } vec_t;

    always #5 clk = ~clk;

    fp_addsub_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a_in   (op_a_in),
        .op_b_in   (op_b_in),
        .sub_in    (sub_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .invalid   (invalid)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        op_a_in  = a;
        op_b_in  = b;
        sub_in   = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Cycles from the accepting edge until out_valid is seen; -1 on timeout.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic handoff;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({in_ready, out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_hs: in_ready/out_valid got %b want 10", {in_ready, out_valid});
        end
        vectors++;
        if (result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_result: got %h want 00000000", result);
        end
        vectors++;
        if ({overflow, underflow, invalid} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 000", {overflow, underflow, invalid});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_arith;
        vec_t tv[$];
        int   lat;
        tv.push_back('{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 5});
        tv.push_back('{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000, 5});
        tv.push_back('{32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000, 3'b000, 5});
        tv.push_back('{32'h3FC00000, 32'hBFC00000, 1'b0, 32'h00000000, 3'b000, 5});
        tv.push_back('{32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 3'b000, 5});
        tv.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100, 5});
        tv.push_back('{32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 3'b000, 5});
        tv.push_back('{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b010, 5});
        tv.push_back('{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 3'b000, 5});
        foreach (tv[i]) begin
            issue(tv[i].a, tv[i].b, tv[i].s);
            wait_valid(lat);
            vectors++;
            if (lat !== tv[i].exp_lat) begin
                miscompares++;
                $display("FAIL arith[%0d]_latency: got %0d want %0d", i, lat, tv[i].exp_lat);
            end
            vectors++;
            if (result !== tv[i].exp_res) begin
                miscompares++;
                $display("FAIL arith[%0d]_result: %h op %h got %h want %h",
                         i, tv[i].a, tv[i].b, result, tv[i].exp_res);
            end
            vectors++;
            if ({overflow, underflow, invalid} !== tv[i].exp_flags) begin
                miscompares++;
                $display("FAIL arith[%0d]_flags: got %b want %b",
                         i, {overflow, underflow, invalid}, tv[i].exp_flags);
            end
            handoff();
        end
    endtask

    task automatic test_special;
        vec_t tv[$];
        int   lat;
        tv.push_back('{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b001, 2});
        tv.push_back('{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b001, 2});
        tv.push_back('{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000, 2});
        tv.push_back('{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000, 2});
        tv.push_back('{32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 3'b000, 2});
        tv.push_back('{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000, 2});
        tv.push_back('{32'hC0400000, 32'h00000000, 1'b0, 32'hC0400000, 3'b000, 2});
        foreach (tv[i]) begin
            issue(tv[i].a, tv[i].b, tv[i].s);
            wait_valid(lat);
            vectors++;
            if (lat !== tv[i].exp_lat) begin
                miscompares++;
                $display("FAIL special[%0d]_latency: got %0d want %0d", i, lat, tv[i].exp_lat);
            end
            vectors++;
            if (result !== tv[i].exp_res) begin
                miscompares++;
                $display("FAIL special[%0d]_result: %h op %h got %h want %h",
                         i, tv[i].a, tv[i].b, result, tv[i].exp_res);
            end
            vectors++;
            if ({overflow, underflow, invalid} !== tv[i].exp_flags) begin
                miscompares++;
                $display("FAIL special[%0d]_flags: got %b want %b",
                         i, {overflow, underflow, invalid}, tv[i].exp_flags);
            end
            handoff();
        end
    endtask

    task automatic test_backpressure;
        int lat;
        int seen_valid;
        issue(32'h7F800000, 32'h7F800000, 1'b1);   // Inf - Inf: invalid
        wait_valid(lat);
        vectors++;
        if (lat !== 2) begin
            miscompares++;
            $display("FAIL bp_latency: got %0d want 2", lat);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            op_a_in  = 32'h3F800000;
            op_b_in  = 32'h3F800000;
            sub_in   = 1'b0;
            @(posedge clk);
            #1;
            vectors++;
            if ({out_valid, in_ready, invalid} !== 3'b101) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: valid/ready/invalid got %b want 101",
                         c, {out_valid, in_ready, invalid});
            end
            vectors++;
            if (result !== 32'h7FC00000) begin
                miscompares++;
                $display("FAIL bp_result[%0d]: got %h want 7fc00000", c, result);
            end
        end
        in_valid = 1'b0;
        handoff();
        vectors++;
        if ({out_valid, in_ready, overflow, underflow, invalid} !== 5'b01000) begin
            miscompares++;
            $display("FAIL bp_handoff: valid/ready/flags got %b want 01000",
                     {out_valid, in_ready, overflow, underflow, invalid});
        end
        seen_valid = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid++;
        end
        vectors++;
        if (seen_valid !== 0) begin
            miscompares++;
            $display("FAIL bp_ignored_input: out_valid cycles got %0d want 0", seen_valid);
        end
    endtask

    task automatic test_reset_midflight;
        int seen_valid;
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0);
        @(posedge clk);   // ALIGN
        @(posedge clk);   // MANT
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL rst_mid: valid/ready got %b want 01", {out_valid, in_ready});
        end
        seen_valid = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid || overflow) seen_valid++;
        end
        vectors++;
        if (seen_valid !== 0) begin
            miscompares++;
            $display("FAIL rst_mid_discard: stray output cycles got %0d want 0", seen_valid);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        issue(32'h3F800000, 32'h3F800000, 1'b0);
        wait_valid(lat);
        vectors++;
        if (lat !== 5) begin
            miscompares++;
            $display("FAIL b2b_first_latency: got %0d want 5", lat);
        end
        vectors++;
        if (result !== 32'h40000000) begin
            miscompares++;
            $display("FAIL b2b_first_result: got %h want 40000000", result);
        end
        handoff();
        issue(32'h40400000, 32'h40400000, 1'b0);   // 3 + 3 = 6
        wait_valid(lat);
        vectors++;
        if (lat !== 5) begin
            miscompares++;
            $display("FAIL b2b_second_latency: got %0d want 5", lat);
        end
        vectors++;
        if (result !== 32'h40C00000) begin
            miscompares++;
            $display("FAIL b2b_second_result: got %h want 40c00000", result);
        end
        handoff();
    endtask

    initial begin
        test_reset();
        test_arith();
        test_special();
        test_backpressure();
        test_reset_midflight();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fp_addsub_seq.md
Name: fp_addsub_seq

Overview:
Multi-cycle FP32 add/subtract sequencer. It time-shares a single existing addsub_block instance (24-bit, sel=0 add, sel=1 subtract, c_out) across exponent compare, mantissa add/sub and exponent adjust. A valid/ready handshake sits on each side, and one operation is in flight at a time. It sits between the FPU operand issue logic and the result writeback.

Parameters:
EXP_W, 8, exponent width; fixed for FP32.
MAN_W, 23, stored fraction width; MAN_W+1 must equal 24, the addsub_block width.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  operands valid
in_ready  out  1  block can accept; high only in IDLE
op_a_in  in  32  FP32 operand A
op_b_in  in  32  FP32 operand B
sub_in  in  1  0: A+B, 1: A-B
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  32  FP32 result
overflow  out  1  result saturated to ±Inf
underflow  out  1  result flushed to ±0
invalid  out  1  NaN operand or Inf-Inf

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: in_ready=1 (IDLE), out_valid=0, result=0, overflow=0, underflow=0, invalid=0. All internal registers are cleared.
- FSM states: IDLE, SPECIAL, EXP, ALIGN, MANT, NORM, DONE.
- IDLE: in_valid & in_ready captures operands.
  - Effective sign of B is sign_b XOR sub_in.
  - If either operand is NaN/Inf/zero/denormal, go to SPECIAL; otherwise go to EXP.
- SPECIAL produces its result directly:
  - Denormals are treated as zero (FTZ).
  - NaN, or Inf plus opposite-signed Inf → 32'h7FC00000, invalid=1.
  - Inf with anything else → that Inf.
  - Zero with X → X. Zero with opposite-signed zero → +0.
  - Next state is DONE. Latency from the accepting edge to out_valid is 2 cycles.
- EXP: shared block computes {16'b0,ea} - {16'b0,eb} with sel=1.
  - Operands are ordered so the larger magnitude is first: larger exponent, or if exponents are equal, larger mantissa (combinational compare).
  - Result sign is the sign of the larger-magnitude operand.
- ALIGN: smaller mantissa (hidden bit included) is shifted right by the difference.
  - A difference ≥ 24 gives a zero mantissa.
  - Shifted-out bits are discarded (round toward zero, truncation).
- MANT: shared block adds the mantissas (sel=0) on effective add, or subtracts them (sel=1) on effective subtract. Ordering guarantees no borrow.
- NORM: shared block adjusts the exponent.
  - Add with c_out=1: mantissa >>1, exponent+1.
  - Otherwise: mantissa <<lzc, exponent-lzc, where lzc is the leading-zero count of the 24-bit sum.
  - Zero sum gives +0, flags clear.
  - Exponent ≥255 gives ±Inf (7F800000/FF800000) with overflow=1.
  - Exponent ≤0 gives ±0 with underflow=1.
- DONE: out_valid=1. result and flags are held stable until out_ready=1, then out_valid drops and the FSM returns to IDLE.
  - No same-cycle re-accept: in_ready rises the cycle after handoff.
- Normal-path latency: out_valid asserts 5 cycles after the accepting edge (EXP, ALIGN, MANT, NORM, then DONE registered).
- in_valid and operands are ignored outside IDLE.
- Shared block operand mux:
  - Inputs a_in/b_in/sel are driven only from the FSM state.
  - Block output is registered at the end of EXP, MANT and NORM.
- rst at any state goes to IDLE on the next edge. The in-flight op is discarded, out_valid=0, flags=0.
- Flags are valid only while out_valid=1, and are cleared on handoff.

Decomposition:
- Package fp_pkg holds:
  - state enum;
  - EXP_W, MAN_W, BIAS=127;
  - constants QNAN=32'h7FC00000, POS_INF=32'h7F800000, NEG_INF=32'hFF800000;
  - field-extract typedef struct {sign, exp, frac}.
- Sub-module lzc24: combinational 24-bit leading-zero counter, 5-bit output, 24 for all zero.
- Reuses the existing addsub_block; no copy of it.

Test Plan:
1. 3F800000 + 3F800000, sub_in=0 → result 40000000, flags 0, out_valid exactly 5 cycles after accept.
2. 40400000 - 3F800000, sub_in=1 → 40000000. Also 3F800000 - 40400000 → C0000000 (ordering swap, sign from larger).
3. 3FC00000 + BFC00000 → 00000000. Also 3F800001 - 3F800000 → 34000000 (lzc path, shift 23).
4. Specials (each with 2-cycle latency):
   - 7F800000 + FF800000 → 7FC00000, invalid=1.
   - 7FC00001 + 3F800000 → 7FC00000, invalid=1.
   - 00000001 + 3F800000 → 3F800000 (FTZ).
5. Overflow: 7F7FFFFF + 7F7FFFFF → 7F800000, overflow=1. Alignment drop: 4B800000 + 3F800000 → 4B800000 (exponent difference 24, operand discarded).
6. Backpressure and reset:
   - Hold out_ready=0 for 3 cycles in DONE → result stable, in_ready=0, second in_valid ignored.
   - Assert rst during MANT → next cycle out_valid=0, in_ready=1.
   - A following op 3F800000+3F800000 returns 40000000.
